// File: rtl/and_gate_reg.sv
// rtl/and_gate_reg.sv - bitwise 2-input AND leaf cell with register pipeline, valid tag, reduction flags and all-ones counter
module and_gate_reg #(
  parameter int WIDTH      = 1,
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  output logic                 y_all,
  output logic                 y_any,
  output logic [CNT_WIDTH-1:0] ones_cnt,
  input  logic                 cnt_clr
);

  logic [WIDTH-1:0] and_res;

  assign and_res = a & b;

  generate
    if (PIPE_DEPTH == 0) begin : g_comb
      assign y         = and_res;
      assign out_valid = in_valid;
    end else begin : g_pipe
      // Data shifts every cycle regardless of in_valid; the valid bit alone qualifies it.
      logic [WIDTH-1:0]      data_q [PIPE_DEPTH];
      logic [PIPE_DEPTH-1:0] valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DEPTH; i++) begin
            data_q[i] <= '0;
          end
          valid_q <= '0;
        end else begin
          data_q[0]  <= and_res;
          valid_q[0] <= in_valid;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign y         = data_q[PIPE_DEPTH-1];
      assign out_valid = valid_q[PIPE_DEPTH-1];
    end
  endgenerate

  assign y_all = &y;
  assign y_any = |y;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (cnt_clr) begin
      ones_cnt <= '0;
    end else if (out_valid && y_all && (ones_cnt != {CNT_WIDTH{1'b1}})) begin
      ones_cnt <= ones_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_and_gate_reg.sv
// tb/tb_and_gate_reg.sv - directed self-checking bench for and_gate_reg
module tb_and_gate_reg;

  logic clk;
  logic rst_n;

  // WIDTH=1, PIPE_DEPTH=1, CNT_WIDTH=2 instance
  logic       a1, b1, v1, clr1;
  logic       y1, ov1, yall1, yany1;
  logic [1:0] cnt1;

  // three-instance combinational cascade
  logic       ca, cb, cc, cd;
  logic       cab, ccd, cy;
  logic       ov_c0, ov_c1, ov_c2;
  logic       yall_c0, yall_c1, yall_c2, yany_c0, yany_c1, yany_c2;
  logic [7:0] cnt_c0, cnt_c1, cnt_c2;

  // WIDTH=8, PIPE_DEPTH=2 instance
  logic [7:0] aw, bw, yw, cntw;
  logic       vw, clrw, ovw, yallw, yanyw;

  int tests = 0;
  int fails = 0;

  and_gate_reg #(.WIDTH(1), .PIPE_DEPTH(1), .CNT_WIDTH(2)) u_tt (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .out_valid(ov1), .y_all(yall1), .y_any(yany1),
    .ones_cnt(cnt1), .cnt_clr(clr1)
  );

  and_gate_reg #(.WIDTH(1), .PIPE_DEPTH(0), .CNT_WIDTH(8)) u_c0 (
    .clk(clk), .rst_n(rst_n), .a(ca), .b(cb), .in_valid(1'b1),
    .y(cab), .out_valid(ov_c0), .y_all(yall_c0), .y_any(yany_c0),
    .ones_cnt(cnt_c0), .cnt_clr(1'b0)
  );

  and_gate_reg #(.WIDTH(1), .PIPE_DEPTH(0), .CNT_WIDTH(8)) u_c1 (
    .clk(clk), .rst_n(rst_n), .a(cc), .b(cd), .in_valid(1'b1),
    .y(ccd), .out_valid(ov_c1), .y_all(yall_c1), .y_any(yany_c1),
    .ones_cnt(cnt_c1), .cnt_clr(1'b0)
  );

  and_gate_reg #(.WIDTH(1), .PIPE_DEPTH(0), .CNT_WIDTH(8)) u_c2 (
    .clk(clk), .rst_n(rst_n), .a(cab), .b(ccd), .in_valid(1'b1),
    .y(cy), .out_valid(ov_c2), .y_all(yall_c2), .y_any(yany_c2),
    .ones_cnt(cnt_c2), .cnt_clr(1'b0)
  );

  and_gate_reg #(.WIDTH(8), .PIPE_DEPTH(2), .CNT_WIDTH(8)) u_w (
    .clk(clk), .rst_n(rst_n), .a(aw), .b(bw), .in_valid(vw),
    .y(yw), .out_valid(ovw), .y_all(yallw), .y_any(yanyw),
    .ones_cnt(cntw), .cnt_clr(clrw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;
    ca = 1'b0; cb = 1'b0; cc = 1'b0; cd = 1'b0;
    aw = 8'h00; bw = 8'h00; vw = 1'b0; clrw = 1'b0;

    // reset state, before any clock edge
    #3;
    chk("rst_y1",    32'(y1),    32'd0);
    chk("rst_ov1",   32'(ov1),   32'd0);
    chk("rst_cnt1",  32'(cnt1),  32'd0);
    chk("rst_yw",    32'(yw),    32'd0);
    chk("rst_ovw",   32'(ovw),   32'd0);
    chk("rst_yallw", 32'(yallw), 32'd0);
    chk("rst_yanyw", 32'(yanyw), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // cascade ((a&b)&(c&d)), combinational
    ca = 1'b0; cb = 1'b0; cc = 1'b0; cd = 1'b0; #1;
    chk("casc_0000", 32'(cy), 32'd0);
    ca = 1'b0; cb = 1'b1; cc = 1'b0; cd = 1'b1; #1;
    chk("casc_0101", 32'(cy), 32'd0);
    ca = 1'b1; cb = 1'b0; cc = 1'b1; cd = 1'b0; #1;
    chk("casc_1010", 32'(cy), 32'd0);
    ca = 1'b1; cb = 1'b1; cc = 1'b1; cd = 1'b1; #1;
    chk("casc_1111", 32'(cy), 32'd1);
    chk("casc_ab",   32'(cab), 32'd1);
    chk("casc_ov",   32'(ov_c2), 32'd1);

    // truth table, one cycle latency
    @(negedge clk); a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
    @(negedge clk);
    chk("tt00_y", 32'(y1), 32'd0); chk("tt00_v", 32'(ov1), 32'd1);
    a1 = 1'b0; b1 = 1'b1;
    @(negedge clk);
    chk("tt01_y", 32'(y1), 32'd0); chk("tt01_v", 32'(ov1), 32'd1);
    a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    chk("tt10_y", 32'(y1), 32'd0); chk("tt10_v", 32'(ov1), 32'd1);
    a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    chk("tt11_y", 32'(y1), 32'd1); chk("tt11_v", 32'(ov1), 32'd1);
    chk("tt_cnt0", 32'(cnt1), 32'd0);

    // valid gating: data and flags propagate, valid and counter do not
    v1 = 1'b0;
    @(negedge clk);
    chk("gate_y",    32'(y1),    32'd1);
    chk("gate_yall", 32'(yall1), 32'd1);
    chk("gate_ov",   32'(ov1),   32'd0);
    chk("gate_cnt1", 32'(cnt1),  32'd1);
    @(negedge clk);
    chk("gate_cnt_hold", 32'(cnt1), 32'd1);

    // saturation at 3 with 2-bit counter
    v1 = 1'b1;
    repeat (5) @(negedge clk);
    chk("sat_cnt", 32'(cnt1), 32'd3);

    // clear wins over a qualifying result
    chk("clr_pre_ov", 32'(ov1), 32'd1);
    clr1 = 1'b1;
    @(negedge clk);
    chk("clr_cnt", 32'(cnt1), 32'd0);
    clr1 = 1'b0;
    @(negedge clk);
    chk("clr_resume", 32'(cnt1), 32'd1);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    // width/flags, two cycle latency
    @(negedge clk); aw = 8'hF0; bw = 8'h3C; vw = 1'b1;
    @(negedge clk);
    chk("w_lat_ov", 32'(ovw), 32'd0);
    aw = 8'hFF; bw = 8'hFF;
    @(negedge clk);
    chk("w_f0_y",    32'(yw),    32'h30);
    chk("w_f0_any",  32'(yanyw), 32'd1);
    chk("w_f0_all",  32'(yallw), 32'd0);
    chk("w_f0_ov",   32'(ovw),   32'd1);
    aw = 8'h00; bw = 8'h00; vw = 1'b0;
    @(negedge clk);
    chk("w_ff_y",    32'(yw),    32'hFF);
    chk("w_ff_all",  32'(yallw), 32'd1);
    chk("w_ff_ov",   32'(ovw),   32'd1);
    aw = 8'h0F; bw = 8'h0F; vw = 1'b1;
    @(negedge clk);
    chk("w_cnt", 32'(cntw), 32'd1);
    @(negedge clk);
    chk("w_flight_y",  32'(yw),  32'h0F);
    chk("w_flight_ov", 32'(ovw), 32'd1);

    // async reset between edges with data in flight
    #2 rst_n = 1'b0;
    #1;
    chk("ar_yw",   32'(yw),   32'd0);
    chk("ar_ovw",  32'(ovw),  32'd0);
    chk("ar_cntw", 32'(cntw), 32'd0);
    chk("ar_any",  32'(yanyw), 32'd0);
    chk("ar_cnt1", 32'(cnt1), 32'd0);
    #1 rst_n = 1'b1;
    vw = 1'b0; aw = 8'hFF; bw = 8'hFF;
    @(negedge clk);
    chk("ar_idle_ov", 32'(ovw), 32'd0);
    vw = 1'b1;
    @(negedge clk);
    chk("ar_lat1_ov", 32'(ovw), 32'd0);
    vw = 1'b0;
    @(negedge clk);
    chk("ar_lat2_ov", 32'(ovw), 32'd1);
    chk("ar_lat2_y",  32'(yw),  32'hFF);
    @(negedge clk);
    chk("ar_after_ov", 32'(ovw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/and_gate_reg.md
# and_gate_reg

Parameterizable bitwise 2-input AND stage with an optional register pipeline, valid tagging and reduction flags. It is the leaf cell for AND trees: a 4-input AND is built from three instances, (a0&a1) and (a2&a3) feeding a third. Clock and reset are shared with the surrounding datapath. A saturating counter records how many valid results were all-ones.

## Interface

Parameters:

- WIDTH, 1: bit width of operands and result.
- PIPE_DEPTH, 1: register stages between inputs and outputs.
  - 0 = purely combinational.
  - Legal range 0..8.
- CNT_WIDTH, 8: width of the all-ones event counter.

Ports:

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle.
- y  output  WIDTH  result a & b, delayed PIPE_DEPTH cycles.
- out_valid  output  1  in_valid delayed PIPE_DEPTH cycles.
- y_all  output  1  &y (all result bits 1).
- y_any  output  1  |y (any result bit 1).
- ones_cnt  output  CNT_WIDTH  count of valid results with y_all=1.
  - Saturates at all-ones.
- cnt_clr  input  1  synchronous clear of ones_cnt.

## Operation

- Result:
  - y = a & b, bitwise, per bit.
  - No X-propagation masking is performed.
- Reduction flags:
  - y_all and y_any are combinational from y (the final stage output).
  - They are not gated by out_valid.
- Pipeline:
  - Each stage holds {valid, data}.
  - Each stage loads unconditionally every cycle; there is no stall or backpressure.
  - Data is captured regardless of in_valid.
  - Only the valid bit qualifies it.
- PIPE_DEPTH = 0:
  - y, out_valid and the flags follow the inputs combinationally.
  - ones_cnt still registers on clk.
- Counter:
  - On each rising edge where cnt_clr=1: ones_cnt <= 0. Clear has priority.
  - Otherwise, if out_valid=1, y_all=1 and ones_cnt is not at its maximum: ones_cnt <= ones_cnt + 1.
  - At its maximum, the counter holds.
- Reset (rst_n low):
  - All stage registers clear to 0: y=0, out_valid=0, ones_cnt=0.
  - Consequently y_all=0 (for WIDTH≥1) and y_any=0.
  - Reset acts immediately, without waiting for clk, and overrides cnt_clr.
- Reset deassertion: stages begin loading on the first rising clk edge after rst_n goes high.

## Timing

- Latency:
  - PIPE_DEPTH cycles from inputs to y/out_valid.
  - Throughput is one result per cycle.
- Reset mid-operation: every in-flight stage is discarded. No valid output appears until new in_valid samples traverse the full depth.
- ones_cnt update: one cycle after the qualifying out_valid/y_all cycle.
- Combinational depth: one AND level plus a WIDTH-input reduction.

## Test plan

- Truth table (WIDTH=1, PIPE_DEPTH=1):
  - Drive (a,b) = (0,0), (0,1), (1,0), (1,1) on successive cycles with in_valid=1.
  - Required: y = 0, 0, 0, 1, each one cycle later, with out_valid=1.
- Cascade check:
  - Three instances form ((a&b)&(c&d)), PIPE_DEPTH=0.
  - Drive abcd = 0000, 0101, 1010, 1111.
  - Required: y = 0, 0, 0, 1 in the same cycle.
- Width/flags (WIDTH=8, PIPE_DEPTH=2):
  - a=8'hF0, b=8'h3C gives y=8'h30, y_any=1, y_all=0.
  - a=b=8'hFF gives y=8'hFF, y_all=1.
  - Both appear 2 cycles after launch.
- Async reset mid-stream:
  - With valid data in flight, pulse rst_n low between clock edges.
  - Required: y=0, out_valid=0, ones_cnt=0 immediately.
  - After release, the first out_valid appears exactly PIPE_DEPTH cycles after the first new in_valid.
- Counter:
  - Set CNT_WIDTH=2 and feed 5 valid all-ones results.
  - Required: ones_cnt reaches 3 and holds.
  - Asserting cnt_clr together with a qualifying result gives ones_cnt=0.
- Valid gating:
  - in_valid=0 with a=b=1.
  - Required: out_valid=0 and ones_cnt unchanged, while y=1 and y_all=1 still propagate.
